icache: RTL and testbench

- Direct-mapped, read-only instruction cache with one-word lines.
- Sits between the instruction-fetch stage (upstream requester) and the memory controller's instruction-fetch port (downstream word fetch).
- Hits return in 1 cycle without touching the memory bus. Misses issue one word fetch to the memory controller and fill the line.
- Honours the global ready signal and branch-flush.

---
 rtl/icache_if.sv | 29 ++
 rtl/icache.sv | 138 +++++++++++++
 tb/tb_icache.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_if
// Brief    : Fetch-side and memory-side signal bundle for the instruction cache.
// Revision : 1.0
// ============================================================================
interface icache_if;
  logic        rdy_in;
  logic        flush_in;
  logic        if_req_in;
  logic [31:0] pc_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_done_in;
  logic [31:0] mem_inst_in;

  modport slave (
    input  rdy_in, flush_in, if_req_in, pc_in, mem_done_in, mem_inst_in,
    output inst_valid_out, inst_out, mem_req_out, mem_addr_out
  );

  modport master (
    output rdy_in, flush_in, if_req_in, pc_in, mem_done_in, mem_inst_in,
    input  inst_valid_out, inst_out, mem_req_out, mem_addr_out
  );
endinterface
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Brief    : Direct-mapped read-only instruction cache, one-word lines.
// Revision : 1.0
// ============================================================================
module icache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_BITS  = 18
) (
  input  logic    clk_in,
  input  logic    rst_in,
  icache_if.slave bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [31:0] inst_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        drop_q;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  accept_hit;
  logic                  accept_miss;
  logic                  fill;
  logic                  deliver;
  logic                  unused_pc_bits;

  assign req_index  = bus.pc_in[INDEX_BITS+1:2];
  assign req_tag    = bus.pc_in[ADDR_BITS-1:INDEX_BITS+2];
  // The fill targets the latched miss address, not the (possibly changed) pc.
  assign fill_index = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag   = mem_addr_q[ADDR_BITS-1:INDEX_BITS+2];
  assign hit        = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign unused_pc_bits = ^bus.pc_in[1:0];

  always_comb begin
    state_d     = state_q;
    accept_hit  = 1'b0;
    accept_miss = 1'b0;
    fill        = 1'b0;
    deliver     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.if_req_in && !bus.flush_in) begin
          if (hit) begin
            accept_hit = 1'b1;
            state_d    = RESP;
          end else begin
            accept_miss = 1'b1;
            state_d     = MISS;
          end
        end
      end
      MISS: begin
        if (bus.mem_done_in) begin
          fill = 1'b1;
          if (drop_q || bus.flush_in) begin
            state_d = IDLE;
          end else begin
            deliver = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else if (bus.rdy_in) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      inst_q     <= 32'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      drop_q     <= 1'b0;
      valid_q    <= '0;
    end else if (bus.rdy_in) begin
      if (accept_hit) begin
        inst_q <= data_mem[req_index];
      end
      if (accept_miss) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= {bus.pc_in[31:2], 2'b00};
      end
      if (fill) begin
        mem_req_q          <= 1'b0;
        valid_q[fill_index] <= 1'b1;
        drop_q             <= 1'b0;
      end
      if (deliver) begin
        inst_q <= bus.mem_inst_in;
      end
      // The controller cannot cancel, so a flush only suppresses delivery.
      if (state_q == MISS && bus.flush_in && !bus.mem_done_in) begin
        drop_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (bus.rdy_in && fill) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= bus.mem_inst_in;
    end
  end

  assign bus.inst_valid_out = (state_q == RESP) && !bus.flush_in;
  assign bus.inst_out       = inst_q;
  assign bus.mem_req_out    = mem_req_q;
  assign bus.mem_addr_out   = mem_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Brief    : Directed, scoreboard-based self-checking bench for icache.
// Revision : 1.0
// ============================================================================
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   v0;
  logic [31:0] exp_q [$];

  icache_if bus ();

  icache #(.INDEX_BITS(7), .ADDR_BITS(18)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and score any delivered instruction.
  task automatic tick();
    @(negedge clk);
    if (bus.inst_valid_out) begin
      n_valid++;
      if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else chk("inst_out", bus.inst_out, exp_q.pop_front());
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                          input bit exp_hit, input int lat);
    int base;
    base = n_valid;
    bus.if_req_in = 1'b1;
    bus.pc_in     = pc;
    exp_q.push_back(data);
    if (exp_hit) begin
      tick();
      chk("hit_latency", n_valid - base, 1);
      chk("hit_mem_req", {31'd0, bus.mem_req_out}, 0);
    end else begin
      for (int i = 0; i < lat; i++) begin
        tick();
        chk("miss_mem_req", {31'd0, bus.mem_req_out}, 1);
        chk("miss_mem_addr", bus.mem_addr_out, {pc[31:2], 2'b00});
      end
      chk("miss_early_valid", n_valid - base, 0);
      bus.mem_done_in = 1'b1;
      bus.mem_inst_in = data;
      tick();
      bus.mem_done_in = 1'b0;
      bus.mem_inst_in = 32'hDEAD_BEEF;
      chk("miss_valid_pulse", n_valid - base, 1);
      chk("miss_req_drop", {31'd0, bus.mem_req_out}, 0);
    end
    bus.if_req_in = 1'b0;
    tick();
    chk("single_pulse", n_valid - base, 1);
  endtask

  initial begin
    bus.rdy_in      = 1'b1;
    bus.flush_in    = 1'b0;
    bus.if_req_in   = 1'b0;
    bus.pc_in       = 32'd0;
    bus.mem_done_in = 1'b0;
    bus.mem_inst_in = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, bus.inst_valid_out}, 0);
    chk("rst_inst", bus.inst_out, 0);
    chk("rst_mem_req", {31'd0, bus.mem_req_out}, 0);
    chk("rst_mem_addr", bus.mem_addr_out, 0);
    chk("rst_valid_bits", {31'd0, |dut.valid_q}, 0);
    rst = 1'b0;
    tick();

    // Cold miss, hit, conflict eviction
    do_fetch(32'h104, 32'h00A00093, 1'b0, 5);
    chk("valid65", {31'd0, dut.valid_q[65]}, 1);
    do_fetch(32'h104, 32'h00A00093, 1'b1, 0);
    do_fetch(32'h304, 32'h11111111, 1'b0, 3);
    do_fetch(32'h104, 32'h00A00093, 1'b0, 2);
    do_fetch(32'h104, 32'h00A00093, 1'b1, 0);

    // Flush mid-miss: line fills, nothing delivered
    v0 = n_valid;
    bus.if_req_in = 1'b1;
    bus.pc_in     = 32'h200;
    tick();
    chk("flush_miss_req", {31'd0, bus.mem_req_out}, 1);
    tick();
    bus.flush_in  = 1'b1;
    bus.if_req_in = 1'b0;
    tick();
    bus.flush_in = 1'b0;
    repeat (2) tick();
    chk("flush_req_held", {31'd0, bus.mem_req_out}, 1);
    bus.mem_done_in = 1'b1;
    bus.mem_inst_in = 32'h33333333;
    tick();
    bus.mem_done_in = 1'b0;
    chk("flush_req_drop", {31'd0, bus.mem_req_out}, 0);
    chk("flush_filled", {31'd0, dut.valid_q[0]}, 1);
    repeat (2) tick();
    chk("flush_no_valid", n_valid - v0, 0);
    do_fetch(32'h200, 32'h33333333, 1'b1, 0);

    // Flush in IDLE ignores the request; flush in RESP gates the pulse
    v0 = n_valid;
    bus.if_req_in = 1'b1;
    bus.pc_in     = 32'h104;
    bus.flush_in  = 1'b1;
    tick();
    chk("flush_idle_valid", n_valid - v0, 0);
    chk("flush_idle_req", {31'd0, bus.mem_req_out}, 0);
    bus.flush_in = 1'b0;
    @(negedge clk);
    bus.flush_in = 1'b1;
    #1;
    chk("flush_resp_gate", {31'd0, bus.inst_valid_out}, 0);
    @(negedge clk);
    bus.flush_in  = 1'b0;
    bus.if_req_in = 1'b0;
    tick();
    chk("flush_resp_none", n_valid - v0, 0);

    // rdy_in low for 3 cycles before RESP delays the hit by 3 cycles
    v0 = n_valid;
    bus.if_req_in = 1'b1;
    bus.pc_in     = 32'h104;
    bus.rdy_in    = 1'b0;
    exp_q.push_back(32'h00A00093);
    repeat (3) tick();
    chk("rdy_frozen", n_valid - v0, 0);
    bus.rdy_in = 1'b1;
    tick();
    chk("rdy_delayed_valid", n_valid - v0, 1);
    bus.if_req_in = 1'b0;
    tick();
    chk("rdy_single_pulse", n_valid - v0, 1);

    // Asynchronous reset mid-miss
    v0 = n_valid;
    bus.if_req_in = 1'b1;
    bus.pc_in     = 32'h400;
    tick();
    chk("rstmiss_req", {31'd0, bus.mem_req_out}, 1);
    rst = 1'b1;
    #1;
    chk("rstmiss_req_low", {31'd0, bus.mem_req_out}, 0);
    chk("rstmiss_valid_low", {31'd0, bus.inst_valid_out}, 0);
    chk("rstmiss_lines", {31'd0, |dut.valid_q}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.if_req_in = 1'b0;
    tick();
    do_fetch(32'h400, 32'h22222222, 1'b0, 3);
    do_fetch(32'h104, 32'h00A00093, 1'b0, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
